// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request legality helper for the LSU.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Stores only know the signed size encodings; loads add the unsigned ones.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bus and memory-side access bus of the LSU.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: request legality check, store replication and
// byte enables, load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  // Legality check operates on the incoming (not yet captured) request.
  input  logic        chk_we,
  input  logic [2:0]  chk_funct3,
  input  logic [1:0]  chk_addr,
  output logic        chk_err,
  // Steering operates on the captured request.
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  // Illegal size encoding or an address not aligned to the access size.
  always_comb begin
    chk_err = !funct3_legal(chk_we, chk_funct3)
           || ((chk_funct3[1:0] == 2'b01) && chk_addr[0])
           || ((chk_funct3[1:0] == 2'b10) && (chk_addr != 2'b00));
  end

  // Store data replicated into every lane; enables select the addressed lane(s).
  always_comb begin
    st_wdata = wdata;
    st_be    = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{wdata[7:0]}};
        st_be    = 4'b0001 << addr;
      end
      2'b01: begin
        st_wdata = {2{wdata[15:0]}};
        st_be    = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        st_wdata = wdata;
        st_be    = 4'b1111;
      end
    endcase
    if (!we) begin
      st_be = '0;
    end
  end

  // Shift the addressed lane down to bit 0, then extend by size/sign.
  always_comb begin
    ld_shifted = rdata >> {addr, 3'b000};
    case (funct3)
      F3_B:    ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_BU:   ld_data = {24'h0, ld_shifted[7:0]};
      F3_H:    ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_HU:   ld_data = {16'h0, ld_shifted[15:0]};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: captures one request, checks it, performs a single
// memory access with a timeout and returns aligned load data or an error.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  lsu_req_if.slave    core,
  lsu_mem_if.master   mem
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        chk_err;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;

  lsu_align u_align (
    .chk_we     (core.req_we),
    .chk_funct3 (core.req_funct3),
    .chk_addr   (core.req_addr[1:0]),
    .chk_err    (chk_err),
    .we         (we_q),
    .funct3     (funct3_q),
    .addr       (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (mem.mem_rdata),
    .st_wdata   (st_wdata),
    .st_be      (st_be),
    .ld_data    (ld_data)
  );

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state: bad requests skip the memory access; ack beats timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (core.req_valid) state_d = chk_err ? RESP : ACCESS;
      ACCESS:  if (mem.mem_ack || (cnt_q == CNT_LAST)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, timeout counting and response register updates.
  always_comb begin
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (core.req_valid) begin
          we_d     = core.req_we;
          funct3_d = core.req_funct3;
          addr_d   = core.req_addr;
          wdata_d  = core.req_wdata;
          cnt_d    = '0;
          if (chk_err) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ACCESS: begin
        if (mem.mem_ack) begin
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : ld_data;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state and captured request.
  always_comb begin
    core.req_ready  = (state_q == IDLE);
    core.resp_valid = (state_q == RESP);
    core.resp_rdata = rdata_q;
    core.resp_err   = err_q;
    mem.mem_req     = (state_q == ACCESS);
    mem.mem_we      = (state_q == ACCESS) && we_q;
    mem.mem_addr    = addr_q[31:2];
    mem.mem_wdata   = st_wdata;
    mem.mem_be      = st_be;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, ACCESS cycles without mem_ack before abort with error; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  access request from the core.
REQ-005 req_ready  output  1  unit idle and able to accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I size/sign field: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-008 req_addr  input  32  byte address (ALU result).
REQ-009 req_wdata  input  32  store data (rs2).
REQ-010 resp_valid  output  1  single-cycle completion pulse.
REQ-011 resp_rdata  output  32  aligned, extended load data.
REQ-012 resp_err  output  1  misaligned, illegal funct3 or timeout; qualified by resp_valid.
REQ-013 mem_req  output  1  memory access strobe.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  30  word address, equal to req_addr[31:2].
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_be  output  4  byte enables; bit i covers mem_wdata[8i+7:8i].
REQ-018 mem_ack  input  1  memory completion, valid only while mem_req=1.
REQ-019 mem_rdata  input  32  read word, valid when mem_ack=1.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP. req_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: req_valid=1 SHALL capture we, funct3, addr and wdata into registers.
REQ-022 IDLE: an error request SHALL go to RESP with error set and no mem_req; otherwise go to ACCESS.
REQ-023 Error conditions: funct3 not in the legal set (stores accept only 000/001/010); halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-024 ACCESS: mem_req=1, with mem_we/mem_addr/mem_wdata/mem_be held constant until mem_ack or timeout.
REQ-025 mem_be: byte = 0001<<addr[1:0]; half = 0011<<{addr[1],0}; word = 1111. mem_be SHALL be 0000 for loads.
REQ-026 mem_wdata: byte = data[7:0] in all 4 lanes; half = data[15:0] in both halves; word = data.
REQ-027 Load data: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-028 mem_ack in ACCESS SHALL register resp_rdata and go to RESP. Stores register resp_rdata=0.
REQ-029 Timeout counter: 8 bits, cleared on entry to ACCESS, incremented each ACCESS cycle without ack.
REQ-030 When the count equals TIMEOUT_CYCLES-1 with no ack, go to RESP with resp_err=1 and resp_rdata=0. If ack arrives in that same cycle, ack wins and no error is reported.
REQ-031 RESP: resp_valid=1 for exactly one cycle, then return to IDLE. A new request is accepted no earlier than the following cycle.
REQ-032 Latency: request accepted in cycle N, zero-wait ack in N+1 gives resp_valid in N+2; an error request gives resp_valid in N+1.
REQ-033 Outside ACCESS: mem_req=0 and mem_we=0. resp_rdata and resp_err hold their values until the next RESP.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, timeout counter=0, and all outputs 0 except req_ready=1.
REQ-035 Reset during ACCESS or RESP aborts the transaction: mem_req drops asynchronously and no resp_valid is issued.

Structure
REQ-036 lsu_pkg SHALL hold the funct3 constants, the state enumeration and the default TIMEOUT_CYCLES.
REQ-037 One combinational sub-module, lsu_align, SHALL implement store lane steering, byte enables, load extraction/extension and the misalignment check.

Verification
REQ-038 SB addr=0x103, wdata=0x000000A5, zero-wait ack -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x40, resp_valid in N+2, err=0.
REQ-039 LH addr=0x102, mem_rdata=0x8001FFFF -> resp_rdata=0xFFFF8001; LHU at the same address -> 0x00008001.
REQ-040 LW addr=0x101 -> resp_valid in N+1, resp_err=1, mem_req never asserted.
REQ-041 LW with mem_ack never asserted, TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, then resp_err=1 and resp_rdata=0.
REQ-042 rst pulse during ACCESS -> mem_req=0 in the same cycle, no resp_valid, req_ready=1, and the next request completes normally.
REQ-043 Back-to-back requests with req_valid held high -> each accepted only while req_ready=1, exactly one resp_valid per request, and mem_* stable throughout wait states.
